// File: rtl/error_combiner_if.sv
// Bundles the weight/error operand bus and the combined error result of error_combiner.
// The master drives operands and observes the result; the slave is the combiner itself.
interface error_combiner_if #(
    parameter int WEIGHT_WIDTH = 4,
    parameter int ERROR_WIDTH  = 5
);
    logic signed [WEIGHT_WIDTH-1:0] weight_0_i;
    logic signed [WEIGHT_WIDTH-1:0] weight_1_i;
    logic signed [WEIGHT_WIDTH-1:0] weight_2_i;
    logic signed [WEIGHT_WIDTH-1:0] weight_3_i;
    logic signed [ERROR_WIDTH-1:0]  error_0_i;
    logic signed [ERROR_WIDTH-1:0]  error_1_i;
    logic signed [ERROR_WIDTH-1:0]  error_2_i;
    logic signed [ERROR_WIDTH-1:0]  error_3_i;
    logic signed [ERROR_WIDTH-1:0]  error_comb_o;

    modport master (
        output weight_0_i, weight_1_i, weight_2_i, weight_3_i,
        output error_0_i, error_1_i, error_2_i, error_3_i,
        input  error_comb_o
    );

    modport slave (
        input  weight_0_i, weight_1_i, weight_2_i, weight_3_i,
        input  error_0_i, error_1_i, error_2_i, error_3_i,
        output error_comb_o
    );
endinterface

// File: rtl/error_combiner.sv
// Two-stage weighted combiner of four signed phase-error samples: registered products,
// then sum, floor-scale by the weight fraction bits, saturate and register the result.
module error_combiner #(
    parameter int WEIGHT_WIDTH     = 4,
    parameter int ERROR_WIDTH      = 5,
    parameter int WEIGHT_FRAC_BITS = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    error_combiner_if.slave     bus
);
    localparam int PW = WEIGHT_WIDTH + ERROR_WIDTH;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ERROR_WIDTH+1){1'b0}}, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [ERROR_WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
        logic signed [ERROR_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[ERROR_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[ERROR_WIDTH-1:0];
        end else begin
            r = v[ERROR_WIDTH-1:0];
        end
        return r;
    endfunction

    logic signed [WEIGHT_WIDTH-1:0] weight_s [4];
    logic signed [ERROR_WIDTH-1:0]  error_s  [4];
    logic signed [PW-1:0]           prod_d   [4];
    logic signed [PW-1:0]           prod_q   [4];
    logic signed [SW-1:0]           sum_s;
    logic signed [SW-1:0]           shift_s;
    logic signed [ERROR_WIDTH-1:0]  error_comb_d;
    logic signed [ERROR_WIDTH-1:0]  error_comb_q;

    // Gather the interface operands into indexable arrays.
    always_comb begin
        weight_s[0] = bus.weight_0_i;
        weight_s[1] = bus.weight_1_i;
        weight_s[2] = bus.weight_2_i;
        weight_s[3] = bus.weight_3_i;
        error_s[0]  = bus.error_0_i;
        error_s[1]  = bus.error_1_i;
        error_s[2]  = bus.error_2_i;
        error_s[3]  = bus.error_3_i;
    end

    // Stage 1: full-precision signed products, operands sign-extended to product width.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prod_d[k] = $signed({{ERROR_WIDTH{weight_s[k][WEIGHT_WIDTH-1]}}, weight_s[k]})
                      * $signed({{WEIGHT_WIDTH{error_s[k][ERROR_WIDTH-1]}}, error_s[k]});
        end
    end

    // Stage 2: two guard bits keep the four-way sum exact; >>> floors toward minus infinity.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int k = 0; k < 4; k++) begin
            sum_s = sum_s + $signed({{2{prod_q[k][PW-1]}}, prod_q[k]});
        end
        shift_s      = sum_s >>> WEIGHT_FRAC_BITS;
        error_comb_d = saturate(shift_s);
    end

    // Pipeline registers; synchronous reset flushes both stages.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < 4; k++) begin
                prod_q[k] <= {PW{1'b0}};
            end
            error_comb_q <= {ERROR_WIDTH{1'b0}};
        end else begin
            for (int k = 0; k < 4; k++) begin
                prod_q[k] <= prod_d[k];
            end
            error_comb_q <= error_comb_d;
        end
    end

    assign bus.error_comb_o = error_comb_q;
endmodule

// File: tb/tb_error_combiner.sv
// Scoreboard bench for error_combiner: directed scenarios plus random operands, checked
// against a floor-divide/saturate reference model through a due-cycle expectation queue.
module tb_error_combiner;
    localparam int WW = 4;
    localparam int EW = 5;
    localparam int FB = 2;

    typedef struct {
        int                    due;
        logic signed [EW-1:0]  exp;
        string                 name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   prev_model;
    bit   done;
    exp_t sb_q [$];

    error_combiner_if #(.WEIGHT_WIDTH(WW), .ERROR_WIDTH(EW)) bus ();

    error_combiner #(
        .WEIGHT_WIDTH(WW),
        .ERROR_WIDTH(EW),
        .WEIGHT_FRAC_BITS(FB)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expectations can be tagged with the edge that produces them.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: floor(sum / 2^FB) then clamp to the output range.
    function automatic int ref_model(input int w0, input int w1, input int w2, input int w3,
                                     input int e0, input int e1, input int e2, input int e3);
        int s;
        int d;
        int lo;
        int hi;
        s  = w0 * e0 + w1 * e1 + w2 * e2 + w3 * e3;
        d  = 1 << FB;
        if (s >= 0) t_floor: begin
            s = s / d;
        end else begin
            s = -((-s + d - 1) / d);
        end
        hi = (1 << (EW - 1)) - 1;
        lo = -(1 << (EW - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    // Drive one sample before the next edge; the output after that edge reflects the previous sample.
    task automatic apply(input int w0, input int w1, input int w2, input int w3,
                         input int e0, input int e1, input int e2, input int e3,
                         input bit rst, input string name);
        exp_t item;
        @(negedge clk);
        reset          = rst;
        bus.weight_0_i = WW'(w0);
        bus.weight_1_i = WW'(w1);
        bus.weight_2_i = WW'(w2);
        bus.weight_3_i = WW'(w3);
        bus.error_0_i  = EW'(e0);
        bus.error_1_i  = EW'(e1);
        bus.error_2_i  = EW'(e2);
        bus.error_3_i  = EW'(e3);
        item.due  = cyc + 1;
        item.exp  = rst ? EW'(0) : EW'(prev_model);
        item.name = name;
        sb_q.push_back(item);
        prev_model = rst ? 0 : ref_model(w0, w1, w2, w3, e0, e1, e2, e3);
    endtask

    // Monitor: compare every expectation whose producing edge has passed.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t it;
            it = sb_q.pop_front();
            vectors = vectors + 1;
            if (bus.error_comb_o !== it.exp) begin
                miscompares = miscompares + 1;
                $display("FAIL %s @edge %0d: got %0d, expected %0d",
                         it.name, it.due, bus.error_comb_o, it.exp);
            end
        end
    end

    initial begin
        int e;
        int w [4];
        int x [4];
        int guard;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        prev_model  = 0;
        done        = 1'b0;
        reset       = 1'b1;

        // Reset held with nonzero operands, then release and mid-stream reassert.
        repeat (3) apply(4, 0, 0, 0, -16, 0, 0, 0, 1'b1, "reset_hold");
        repeat (3) apply(4, 0, 0, 0, -16, 0, 0, 0, 1'b0, "reset_release");
        apply(4, 0, 0, 0, 7, 0, 0, 0, 1'b0, "pre_midreset");
        apply(4, 0, 0, 0, 9, 0, 0, 0, 1'b1, "midreset");
        apply(4, 0, 0, 0, 5, 0, 0, 0, 1'b0, "post_midreset");

        // Unity pass-through with wrap of e0.
        e = -16;
        for (int i = 0; i < 40; i++) begin
            apply(4, 0, 0, 0, e, 0, 0, 0, 1'b0, "unity");
            e = (e == 15) ? -16 : e + 1;
        end

        // Saturation corners.
        apply(4, 4, 4, 4, -16, -16, -16, -16, 1'b0, "sat_neg");
        apply(7, 0, 0, 0, 15, 0, 0, 0, 1'b0, "sat_pos");
        apply(-8, 0, 0, 0, -16, 0, 0, 0, 1'b0, "sat_negw");

        // Floor behaviour.
        apply(1, 0, 0, 0, 3, 0, 0, 0, 1'b0, "floor_p3");
        apply(1, 0, 0, 0, -3, 0, 0, 0, 1'b0, "floor_m3");
        apply(1, 0, 0, 0, -1, 0, 0, 0, 1'b0, "floor_m1");

        // Blending and sign inversion, plus muting of unused inputs.
        apply(2, 2, 0, 0, 5, -3, 11, -9, 1'b0, "blend");
        apply(2, -4, 0, 0, 5, -3, -16, 15, 1'b0, "blend_neg");

        // Random per-cycle operand changes.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = int'($urandom_range(15)) - 8;
                x[k] = int'($urandom_range(31)) - 16;
            end
            apply(w[0], w[1], w[2], w[3], x[0], x[1], x[2], x[3], 1'b0, "random");
        end

        // Drain remaining expectations with a bounded wait.
        repeat (3) apply(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "drain");
        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (sb_q.size() > 0) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
